// File: rtl/cia_pkg.sv
// Shared CIA types: pad-stage bus sample, register-interface strobe bundle
// and the default phi2 watchdog length.
package cia;

    localparam int CIA_WDOG_DEFAULT = 255;

    typedef struct packed {
        logic       phi2;
        logic       res_n;
        logic       cs_n;
        logic       r_w_n;
        logic [3:0] addr;
        logic [7:0] data;
    } bus_i_t;

    typedef struct packed {
        logic       we;
        logic       re;
        logic [3:0] addr;
        logic [7:0] wdata;
    } reg_strobe_t;

endpackage

// File: rtl/cia_edge.sv
// Edge detector for an already-synchronized 1-bit signal: one-cycle rise/fall ticks.
// Ticks are forced low while rst is high so no edge is reported out of reset.
module cia_edge (
    input  logic clk,
    input  logic rst,
    input  logic sig,
    output logic sig_q,
    output logic rise,
    output logic fall
);

    logic sig_d;

    assign sig_d = sig;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sig_q <= 1'b0;
        end else begin
            sig_q <= sig_d;
        end
    end

    assign rise = ~rst & ~sig_q & sig;
    assign fall = ~rst & sig_q & ~sig;

endmodule

// File: rtl/cia_bus.sv
// CIA bus interface: phi2 edge ticks, register access strobes, phi1-aligned chip reset.
// Optional phi2 watchdog is compiled in with CIA_PHI2_WATCHDOG_EN.
module cia_bus
    import cia::*;
#(
    parameter int WDOG_CYCLES = CIA_WDOG_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  bus_i_t     bus_i,
    input  logic [7:0] rdata,
    output logic [7:0] data_out,
    output logic [3:0] reg_addr,
    output logic [7:0] reg_wdata,
    output logic       reg_we,
    output logic       reg_re,
    output logic       phi2_rise,
    output logic       phi2_fall,
    output logic       cia_res,
    output logic       phi2_lost
);

    localparam logic [7:0] WDOG_LIMIT = 8'(WDOG_CYCLES);

    logic        phi2_q;
    reg_strobe_t strobe_q, strobe_d;
    logic [7:0]  data_out_q, data_out_d;
    logic        cia_res_q, cia_res_d;
    logic        cs_n_hold_q, cs_n_hold_d;
    logic        r_w_n_hold_q, r_w_n_hold_d;
    logic        access;

    cia_edge u_phi2_edge (
        .clk  (clk),
        .rst  (rst),
        .sig  (bus_i.phi2),
        .sig_q(phi2_q),
        .rise (phi2_rise),
        .fall (phi2_fall)
    );

    // Select/direction are taken only from phi2-high samples, so a chip select
    // that appears during phi1 alone never qualifies an access.
    assign access = phi2_fall & ~cs_n_hold_q & ~cia_res_q & bus_i.res_n;

    always_comb begin
        strobe_d     = strobe_q;
        strobe_d.we  = 1'b0;
        strobe_d.re  = 1'b0;
        data_out_d   = data_out_q;
        cs_n_hold_d  = cs_n_hold_q;
        r_w_n_hold_d = r_w_n_hold_q;
        cia_res_d    = cia_res_q;

        if (phi2_q) begin
            strobe_d.addr = bus_i.addr;
            data_out_d    = rdata;
        end
        if (bus_i.phi2) begin
            cs_n_hold_d  = bus_i.cs_n;
            r_w_n_hold_d = bus_i.r_w_n;
        end
        if (access) begin
            strobe_d.we = ~r_w_n_hold_q;
            strobe_d.re = r_w_n_hold_q;
            if (!r_w_n_hold_q) begin
                strobe_d.wdata = bus_i.data;
            end
        end
        // Release only on a phi2 fall so the chip leaves reset aligned to phi1.
        if (!bus_i.res_n) begin
            cia_res_d = 1'b1;
        end else if (phi2_fall) begin
            cia_res_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            strobe_q     <= '0;
            data_out_q   <= 8'h00;
            cs_n_hold_q  <= 1'b1;
            r_w_n_hold_q <= 1'b1;
            cia_res_q    <= 1'b1;
        end else begin
            strobe_q     <= strobe_d;
            data_out_q   <= data_out_d;
            cs_n_hold_q  <= cs_n_hold_d;
            r_w_n_hold_q <= r_w_n_hold_d;
            cia_res_q    <= cia_res_d;
        end
    end

    assign data_out  = data_out_q;
    assign reg_addr  = strobe_q.addr;
    assign reg_wdata = strobe_q.wdata;
    assign reg_we    = strobe_q.we;
    assign reg_re    = strobe_q.re;
    assign cia_res   = cia_res_q;

`ifdef CIA_PHI2_WATCHDOG_EN
    logic [7:0] wdog_q, wdog_d;

    always_comb begin
        wdog_d = wdog_q;
        if (phi2_rise || phi2_fall) begin
            wdog_d = 8'h00;
        end else if (wdog_q != WDOG_LIMIT) begin
            wdog_d = wdog_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wdog_q <= 8'h00;
        end else begin
            wdog_q <= wdog_d;
        end
    end

    assign phi2_lost = (wdog_q == WDOG_LIMIT);
`else
    logic wdog_unused;
    assign wdog_unused = ^WDOG_LIMIT;
    assign phi2_lost   = 1'b0;
`endif

endmodule

// File: tb/tb_cia_bus.sv
// Directed self-checking bench for cia_bus: writes, reads, deselect, res_n abort,
// phi2 watchdog (CIA_PHI2_WATCHDOG_EN aware) and asynchronous rst mid-write.
module tb_cia_bus;
    import cia::*;

`ifdef CIA_PHI2_WATCHDOG_EN
    localparam int LOST_EXP = 1;
`else
    localparam int LOST_EXP = 0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    bus_i_t     bus_i;
    logic [7:0] rdata;
    logic [7:0] data_out;
    logic [3:0] reg_addr;
    logic [7:0] reg_wdata;
    logic       reg_we;
    logic       reg_re;
    logic       phi2_rise;
    logic       phi2_fall;
    logic       cia_res;
    logic       phi2_lost;

    int checks = 0;
    int errors = 0;
    int rise_cnt = 0, fall_cnt = 0, we_cnt = 0, re_cnt = 0, both_cnt = 0;
    int b_rise, b_fall, b_we, b_re;

    always #5 clk = ~clk;

    cia_bus #(.WDOG_CYCLES(16)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus_i    (bus_i),
        .rdata    (rdata),
        .data_out (data_out),
        .reg_addr (reg_addr),
        .reg_wdata(reg_wdata),
        .reg_we   (reg_we),
        .reg_re   (reg_re),
        .phi2_rise(phi2_rise),
        .phi2_fall(phi2_fall),
        .cia_res  (cia_res),
        .phi2_lost(phi2_lost)
    );

    always @(negedge clk) begin
        if (phi2_rise) rise_cnt++;
        if (phi2_fall) fall_cnt++;
        if (reg_we) we_cnt++;
        if (reg_re) re_cnt++;
        if (reg_we && reg_re) both_cnt++;
    end

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic snap();
        b_rise = rise_cnt;
        b_fall = fall_cnt;
        b_we   = we_cnt;
        b_re   = re_cnt;
    endtask

    initial begin
        bus_i       = '0;
        bus_i.res_n = 1'b1;
        bus_i.cs_n  = 1'b1;
        bus_i.r_w_n = 1'b1;
        rdata       = 8'h00;
        #2;
        tick(2);

        // Reset values hold even with phi2 high and a live address
        bus_i.phi2 = 1'b1;
        bus_i.addr = 4'hF;
        rdata      = 8'hEE;
        tick(2);
        chk("rst_cia_res", 32'(cia_res), 1);
        chk("rst_data_out", 32'(data_out), 'h00);
        chk("rst_reg_addr", 32'(reg_addr), 'h0);
        chk("rst_reg_wdata", 32'(reg_wdata), 'h00);
        chk("rst_reg_we", 32'(reg_we), 0);
        chk("rst_reg_re", 32'(reg_re), 0);
        chk("rst_phi2_rise", 32'(phi2_rise), 0);
        chk("rst_phi2_fall", 32'(phi2_fall), 0);
        chk("rst_phi2_lost", 32'(phi2_lost), 0);

        bus_i.phi2 = 1'b0;
        bus_i.addr = 4'h0;
        rdata      = 8'h00;
        tick(1);
        rst = 1'b0;
        tick(2);
        chk("post_rst_cia_res", 32'(cia_res), 1);

        // First phi2 cycle releases cia_res one clk after the fall
        bus_i.phi2 = 1'b1;
        #1;
        chk("rise_tick", 32'(phi2_rise), 1);
        tick(3);
        bus_i.phi2 = 1'b0;
        #1;
        chk("fall_tick", 32'(phi2_fall), 1);
        chk("cia_res_before_release", 32'(cia_res), 1);
        tick(1);
        chk("cia_res_released", 32'(cia_res), 0);
        chk("fall_tick_one_clk", 32'(phi2_fall), 0);
        tick(2);

        // Write D <= 81
        snap();
        bus_i.cs_n  = 1'b0;
        bus_i.r_w_n = 1'b0;
        bus_i.addr  = 4'hD;
        bus_i.data  = 8'h81;
        bus_i.phi2  = 1'b1;
        tick(3);
        chk("wr_addr_follow", 32'(reg_addr), 'hD);
        bus_i.phi2 = 1'b0;
        chk("wr_we_not_early", 32'(reg_we), 0);
        tick(1);
        chk("wr_we", 32'(reg_we), 1);
        chk("wr_wdata", 32'(reg_wdata), 'h81);
        chk("wr_addr", 32'(reg_addr), 'hD);
        chk("wr_re", 32'(reg_re), 0);
        bus_i.cs_n  = 1'b1;
        bus_i.r_w_n = 1'b1;
        bus_i.data  = 8'h00;
        tick(1);
        chk("wr_we_one_clk", 32'(reg_we), 0);
        chk("wr_wdata_hold", 32'(reg_wdata), 'h81);
        tick(1);
        chk("wr_we_count", 32'(we_cnt - b_we), 1);
        chk("wr_re_count", 32'(re_cnt - b_re), 0);

        // Read 0 -> 5A
        snap();
        rdata       = 8'h5A;
        bus_i.cs_n  = 1'b0;
        bus_i.r_w_n = 1'b1;
        bus_i.addr  = 4'h0;
        bus_i.phi2  = 1'b1;
        tick(2);
        chk("rd_data_out", 32'(data_out), 'h5A);
        chk("rd_addr", 32'(reg_addr), 'h0);
        tick(1);
        bus_i.phi2 = 1'b0;
        tick(1);
        chk("rd_re", 32'(reg_re), 1);
        chk("rd_we", 32'(reg_we), 0);
        chk("rd_data_at_fall", 32'(data_out), 'h5A);
        bus_i.cs_n = 1'b1;
        rdata      = 8'h33;
        tick(1);
        chk("rd_re_one_clk", 32'(reg_re), 0);
        chk("rd_data_hold_phi1", 32'(data_out), 'h5A);
        tick(1);
        chk("rd_re_count", 32'(re_cnt - b_re), 1);
        chk("rd_we_count", 32'(we_cnt - b_we), 0);

        // Deselect over 10 phi2 cycles
        snap();
        for (int i = 0; i < 10; i++) begin
            bus_i.addr  = 4'(i);
            bus_i.data  = 8'(i * 37);
            bus_i.r_w_n = i[0];
            bus_i.cs_n  = 1'b1;
            bus_i.phi2  = 1'b1;
            tick(3);
            bus_i.phi2 = 1'b0;
            tick(3);
        end
        chk("desel_rise_count", 32'(rise_cnt - b_rise), 10);
        chk("desel_fall_count", 32'(fall_cnt - b_fall), 10);
        chk("desel_we_count", 32'(we_cnt - b_we), 0);
        chk("desel_re_count", 32'(re_cnt - b_re), 0);

        // cs_n low only during phi1 must not strobe
        snap();
        bus_i.phi2 = 1'b1;
        tick(3);
        bus_i.phi2  = 1'b0;
        bus_i.cs_n  = 1'b0;
        bus_i.r_w_n = 1'b0;
        tick(3);
        bus_i.cs_n  = 1'b1;
        bus_i.r_w_n = 1'b1;
        chk("phi1_cs_we_count", 32'(we_cnt - b_we), 0);
        chk("phi1_cs_re_count", 32'(re_cnt - b_re), 0);

        // res_n pulse of 3 clk during a write to 4
        snap();
        bus_i.cs_n  = 1'b0;
        bus_i.r_w_n = 1'b0;
        bus_i.addr  = 4'h4;
        bus_i.data  = 8'h44;
        bus_i.phi2  = 1'b1;
        tick(2);
        bus_i.res_n = 1'b0;
        tick(1);
        chk("resn_cia_res_set", 32'(cia_res), 1);
        tick(2);
        bus_i.res_n = 1'b1;
        tick(1);
        chk("resn_cia_res_held", 32'(cia_res), 1);
        bus_i.phi2 = 1'b0;
        tick(1);
        chk("resn_cia_res_release", 32'(cia_res), 0);
        chk("resn_no_we", 32'(reg_we), 0);
        bus_i.cs_n = 1'b1;
        tick(1);
        chk("resn_no_we_late", 32'(reg_we), 0);
        chk("resn_wdata_kept", 32'(reg_wdata), 'h81);
        chk("resn_we_count", 32'(we_cnt - b_we), 0);

        // Watchdog: phi2 held high for 20 clk
        bus_i.phi2 = 1'b1;
        tick(1);
        tick(15);
        chk("wdog_not_yet", 32'(phi2_lost), 0);
        tick(1);
        chk("wdog_lost_16", 32'(phi2_lost), LOST_EXP);
        tick(3);
        chk("wdog_lost_20", 32'(phi2_lost), LOST_EXP);
        bus_i.phi2 = 1'b0;
        chk("wdog_lost_edge_cycle", 32'(phi2_lost), LOST_EXP);
        tick(1);
        chk("wdog_cleared", 32'(phi2_lost), 0);
        tick(2);

        // Asynchronous rst in the fall cycle of a write to 7
        snap();
        bus_i.cs_n  = 1'b0;
        bus_i.r_w_n = 1'b0;
        bus_i.addr  = 4'h7;
        bus_i.data  = 8'h77;
        bus_i.phi2  = 1'b1;
        tick(3);
        chk("arst_addr_before", 32'(reg_addr), 'h7);
        bus_i.phi2 = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("arst_we", 32'(reg_we), 0);
        chk("arst_re", 32'(reg_re), 0);
        chk("arst_fall", 32'(phi2_fall), 0);
        chk("arst_rise", 32'(phi2_rise), 0);
        chk("arst_cia_res", 32'(cia_res), 1);
        chk("arst_reg_addr", 32'(reg_addr), 'h0);
        chk("arst_data_out", 32'(data_out), 'h00);
        chk("arst_wdata", 32'(reg_wdata), 'h00);
        chk("arst_lost", 32'(phi2_lost), 0);
        tick(2);
        rst = 1'b0;
        tick(2);
        chk("arst_no_we_after", 32'(reg_we), 0);
        bus_i.phi2 = 1'b1;
        tick(3);
        bus_i.phi2 = 1'b0;
        tick(3);
        chk("arst_we_count", 32'(we_cnt - b_we), 0);
        chk("arst_cia_res_release", 32'(cia_res), 0);

        // Normal write after recovery
        bus_i.addr = 4'hA;
        bus_i.data = 8'hC3;
        bus_i.phi2 = 1'b1;
        tick(3);
        bus_i.phi2 = 1'b0;
        tick(1);
        chk("recov_we", 32'(reg_we), 1);
        chk("recov_wdata", 32'(reg_wdata), 'hC3);
        chk("recov_addr", 32'(reg_addr), 'hA);
        bus_i.cs_n  = 1'b1;
        bus_i.r_w_n = 1'b1;
        tick(2);
        chk("we_re_never_both", 32'(both_cnt), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
